vending_machine_multi: RTL
==========================

# vending_machine_multi

Parametrised multi-item vending controller, successor to the single-price food/drink machine. Accumulates nickel/dime/quarter credit, vends one of NUM_ITEMS products at run-time prices, and returns change or refunds one coin per cycle using greedy denomination selection. Operation is gated by the face-recognition `auth` verdict supplied by the upstream matcher.

## Interface
- NUM_ITEMS, 4, number of selectable products (≥2)
- CREDIT_W, 8, credit/price width in 5-cent units
- MAX_CREDIT, 40, credit ceiling in units ($2.00); must fit CREDIT_W
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- nickel / dime / quarter  in  1 each  single-cycle coin-insert pulses
- auth  in  1  face match ≥90% verdict, level
- sel_valid  in  1  selection strobe
- sel_item  in  $clog2(NUM_ITEMS)  selected product index
- cancel  in  1  refund request pulse
- price_tbl  in  NUM_ITEMS*CREDIT_W  prices in units, item i at [i*CREDIT_W +: CREDIT_W]
- item_avail  in  NUM_ITEMS  per-item stock present
- dispense  out  1  one-cycle vend pulse
- dispense_item  out  $clog2(NUM_ITEMS)  item vended, valid with dispense
- nickel_out / dime_out / quarter_out  out  1 each  one-cycle pulse = one coin returned
- change_busy  out  1  high in VEND and CHANGE
- credit  out  CREDIT_W  current credit in units
- coin_reject  out  1  one-cycle pulse, inserted coin returned unaccepted
- sel_error  out  1  one-cycle pulse, selection refused

## Operation
- States: IDLE (credit 0), CREDIT (credit>0), VEND, CHANGE. Coin values in units: nickel 1, dime 2, quarter 5.
- Coin accepted only in IDLE/CREDIT, auth high, exactly one coin line high, and credit+value ≤ MAX_CREDIT; credit += value, IDLE→CREDIT. Otherwise coin_reject pulses, credit unchanged.
- Selection in IDLE/CREDIT: refused (sel_error) if auth low, sel_item ≥ NUM_ITEMS, item_avail[sel_item] low, or credit < price. Else credit -= price, →VEND. Price 0 is legal (free vend).
- VEND: dispense=1, dispense_item=accepted index, one cycle; then →CHANGE if credit>0, else →IDLE.
- CHANGE: each cycle pulse exactly one coin: quarter if credit≥5, else dime if ≥2, else nickel; credit decremented same cycle; →IDLE when credit reaches 0.
- cancel in CREDIT →CHANGE (full refund); cancel in IDLE ignored; in VEND/CHANGE ignored.
- auth falling while in CREDIT acts as cancel.
- Simultaneous in IDLE/CREDIT: cancel > sel_valid > coin. Any coin arriving in same cycle as an accepted cancel/selection, or during VEND/CHANGE, is rejected.

## Timing
- All outputs registered; reset value 0 for every output, state IDLE, credit 0.
- Coin at edge N → credit updated at N+1; coin_reject at N+1.
- Accepted selection at N → dispense and reduced credit at N+1; first change coin at N+2.
- Change latency = number of coins, one per cycle, no gaps; change_busy high from N+1 through last change coin.
- cancel at N → first refund coin at N+1.
- Reset assertion mid-VEND/CHANGE: outputs clear immediately, remaining credit discarded.

## Configuration
- VM_AUTH_EN defined: auth gates coins and selections and its falling edge refunds as above.
- Undefined: auth ignored, treated as constantly high; no auth-triggered refund.

## Structure
- Package vm_pkg: state enum, coin unit constants (NICKEL_U, DIME_U, QUARTER_U), greedy-denomination function.
- Sub-module vm_change_unit: given credit, emits one-hot coin select and decremented credit (combinational), instantiated once.

## Test plan
- Prices {7,6,10,3}: quarter, dime, dime → credit 5,7,9; select item0 → dispense item0, credit 2; dime_out one cycle; IDLE.
- Credit 9, select item2 (price 10) → sel_error, credit stays 9; cancel → quarter_out, dime_out, dime_out on consecutive cycles, credit 0.
- Credit 38, quarter → coin_reject, credit 38; nickel+dime same cycle → coin_reject.
- Credit 7, select item1 with item_avail[1]=0 → sel_error; auth low with VM_AUTH_EN → coins rejected; auth drop at credit 5 → quarter_out refund.
- Credit 6, select item1 and quarter same cycle → dispense item1, credit 0, coin_reject; cancel+select same cycle → refund, no dispense.
- Reset low during CHANGE at credit 4 → all outputs 0 immediately, credit 0, IDLE after release.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the multi-item vending controller.
// The optional auth gating is selected with the VM_AUTH_EN macro in vending_machine_multi.
package vm_pkg;

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  // One-hot coin select, bit order {quarter, dime, nickel}
  typedef enum logic [2:0] {
    CoinNone    = 3'b000,
    CoinNickel  = 3'b001,
    CoinDime    = 3'b010,
    CoinQuarter = 3'b100
  } coin_e;

  localparam int unsigned NICKEL_U  = 1;
  localparam int unsigned DIME_U    = 2;
  localparam int unsigned QUARTER_U = 5;

  function automatic coin_e greedy_coin(input int unsigned credit);
    if (credit >= QUARTER_U) return CoinQuarter;
    if (credit >= DIME_U)    return CoinDime;
    if (credit >= NICKEL_U)  return CoinNickel;
    return CoinNone;
  endfunction

  function automatic int unsigned coin_units(input coin_e coin);
    case (coin)
      CoinNickel:  return NICKEL_U;
      CoinDime:    return DIME_U;
      CoinQuarter: return QUARTER_U;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_unit.sv
// Combinational greedy change selector: picks the largest coin not exceeding the
// credit and returns the credit remaining after that coin is paid out.
module vm_change_unit
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit_in,
  output coin_e               coin_sel,
  output logic [CREDIT_W-1:0] credit_next
);

  assign coin_sel    = greedy_coin(32'(credit_in));
  assign credit_next = credit_in - CREDIT_W'(coin_units(coin_sel));

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin credit, priced selection, greedy change/refund.
// Define VM_AUTH_EN to gate coins/selections on auth and refund when auth drops.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned MAX_CREDIT = 40
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            nickel,
  input  logic                            dime,
  input  logic                            quarter,
  input  logic                            auth,
  input  logic                            sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0]    sel_item,
  input  logic                            cancel,
  input  logic [NUM_ITEMS*CREDIT_W-1:0]   price_tbl,
  input  logic [NUM_ITEMS-1:0]            item_avail,
  output logic                            dispense,
  output logic [$clog2(NUM_ITEMS)-1:0]    dispense_item,
  output logic                            nickel_out,
  output logic                            dime_out,
  output logic                            quarter_out,
  output logic                            change_busy,
  output logic [CREDIT_W-1:0]             credit,
  output logic                            coin_reject,
  output logic                            sel_error
);

  localparam int unsigned SelW = $clog2(NUM_ITEMS);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SelW-1:0]     item_q, item_d;
  logic                dispense_q, dispense_d;
  coin_e               coin_out_q, coin_out_d;
  logic                busy_q, busy_d;
  logic                reject_q, reject_d;
  logic                sel_err_q, sel_err_d;

  logic auth_ok;
`ifdef VM_AUTH_EN
  assign auth_ok = auth;
`else
  logic unused_auth;
  assign unused_auth = auth;
  assign auth_ok     = 1'b1;
`endif

  // Price and stock of the selected item; out-of-range indices match nothing.
  logic [CREDIT_W-1:0] price;
  logic                item_ok;
  always_comb begin
    price   = '0;
    item_ok = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == SelW'(i)) begin
        price   = price_tbl[i*CREDIT_W +: CREDIT_W];
        item_ok = item_avail[i];
      end
    end
  end

  logic [CREDIT_W:0] coin_val, coin_sum;
  logic              coin_any, coin_ok;
  always_comb begin
    coin_val = '0;
    unique case ({quarter, dime, nickel})
      3'b001:  coin_val = (CREDIT_W+1)'(NICKEL_U);
      3'b010:  coin_val = (CREDIT_W+1)'(DIME_U);
      3'b100:  coin_val = (CREDIT_W+1)'(QUARTER_U);
      default: coin_val = '0;
    endcase
  end
  assign coin_any = nickel | dime | quarter;
  assign coin_sum = {1'b0, credit_q} + coin_val;
  assign coin_ok  = auth_ok && (coin_val != '0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  coin_e               chg_coin;
  logic [CREDIT_W-1:0] chg_credit;
  vm_change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .credit_in   (credit_q),
    .coin_sel    (chg_coin),
    .credit_next (chg_credit)
  );

  logic emit;
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_d     = item_q;
    dispense_d = 1'b0;
    coin_out_d = CoinNone;
    reject_d   = coin_any;
    sel_err_d  = 1'b0;
    emit       = 1'b0;

    unique case (state_q)
      StIdle, StCredit: begin
        if (state_q == StCredit && (cancel || !auth_ok)) begin
          emit = 1'b1;
        end else if (sel_valid) begin
          if (auth_ok && item_ok && credit_q >= price) begin
            credit_d   = credit_q - price;
            item_d     = sel_item;
            dispense_d = 1'b1;
            state_d    = StVend;
          end else begin
            sel_err_d = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          reject_d = 1'b0;
          state_d  = StCredit;
        end
      end
      StVend: begin
        if (credit_q != '0) emit = 1'b1;
        else                state_d = StIdle;
      end
      StChange: emit = 1'b1;
    endcase

    // Coins are paid on the edge that leaves VEND or takes the cancel, so no gap cycle.
    if (emit) begin
      coin_out_d = chg_coin;
      credit_d   = chg_credit;
      state_d    = (chg_credit == '0) ? StIdle : StChange;
    end
    busy_d = emit || (state_d == StVend);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      item_q     <= '0;
      dispense_q <= 1'b0;
      coin_out_q <= CoinNone;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      dispense_q <= dispense_d;
      coin_out_q <= coin_out_d;
      busy_q     <= busy_d;
      reject_q   <= reject_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign dispense      = dispense_q;
  assign dispense_item = dispense_q ? item_q : '0;
  assign nickel_out    = coin_out_q[0];
  assign dime_out      = coin_out_q[1];
  assign quarter_out   = coin_out_q[2];
  assign change_busy   = busy_q;
  assign credit        = credit_q;
  assign coin_reject   = reject_q;
  assign sel_error     = sel_err_q;

endmodule
